// File: rtl/fadds_pcpi_ctrl.sv
// PCPI front-end for a combinational single-precision FP adder: decodes the
// custom FP-add instructions, holds the adder operands and returns results.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a claimed instruction on the PCPI bus
// EXEC  | adder inputs held, counting down the settle time
// DONE  | one-cycle ready/wr strobe with the result on pcpi_rd
// GAP   | dead cycle while the core retires; pcpi_valid ignored
module fadds_pcpi_ctrl #(
    parameter int unsigned ADD_LATENCY = 1,
    parameter logic [6:0]  OPCODE      = 7'b0001011
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_y
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE, GAP} state_t;

    localparam logic [1:0] OP_FADDS  = 2'd0;
    localparam logic [1:0] OP_FACC   = 2'd1;
    localparam logic [1:0] OP_FACCRD = 2'd2;
    localparam logic [3:0] LAT       = 4'(ADD_LATENCY);

    state_t      state, state_nxt;
    logic [1:0]  op, op_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] acc, acc_nxt;
    logic [31:0] rd_nxt, a_nxt, b_nxt;
    logic        wait_nxt, ready_nxt, wr_nxt;
    logic        hit;
    logic [1:0]  op_dec;

    // funct7 of 0x00..0x02 maps directly onto the op code
    always_comb begin
        hit    = 1'b0;
        op_dec = OP_FADDS;
        if (pcpi_insn[6:0] == OPCODE && pcpi_insn[14:12] == 3'b000 &&
            pcpi_insn[31:27] == 5'b00000 && pcpi_insn[26:25] != 2'b11) begin
            hit    = 1'b1;
            op_dec = pcpi_insn[26:25];
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        rd_nxt    = pcpi_rd;
        a_nxt     = add_a;
        b_nxt     = add_b;
        wait_nxt  = pcpi_wait;
        ready_nxt = 1'b0;
        wr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (pcpi_valid && hit) begin
                    op_nxt    = op_dec;
                    cnt_nxt   = LAT;
                    wait_nxt  = 1'b1;
                    state_nxt = EXEC;
                    case (op_dec)
                        OP_FACC: begin
                            a_nxt = acc;
                            b_nxt = pcpi_rs1;
                        end
                        OP_FACCRD: begin
                            a_nxt = add_a;
                            b_nxt = add_b;
                        end
                        default: begin
                            a_nxt = pcpi_rs1;
                            b_nxt = pcpi_rs2;
                        end
                    endcase
                end
            end
            EXEC: begin
                if (!pcpi_valid) begin
                    // core gave up on the instruction: drop it silently
                    wait_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rd_nxt = (op == OP_FACCRD) ? acc : add_y;
                        if (op == OP_FACC)
                            acc_nxt = add_y;
                        else if (op == OP_FACCRD)
                            acc_nxt = '0;
                        wait_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                        wr_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            op         <= OP_FADDS;
            cnt        <= '0;
            acc        <= '0;
            pcpi_rd    <= '0;
            add_a      <= '0;
            add_b      <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
        end else begin
            state      <= state_nxt;
            op         <= op_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            pcpi_rd    <= rd_nxt;
            add_a      <= a_nxt;
            add_b      <= b_nxt;
            pcpi_wait  <= wait_nxt;
            pcpi_ready <= ready_nxt;
            pcpi_wr    <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_fadds_pcpi_ctrl.sv
// Directed bench for fadds_pcpi_ctrl: four instances at latencies 1/3/4/15,
// each with its own adder stub (small FP adder or plain integer add).
module tb_fadds_pcpi_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] insn = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    int          sel = 0;
    logic        fp_mode = 1'b0;

    logic [3:0]        valid_v, wr_v, wait_v, rdy_v;
    logic [3:0][31:0]  rd_v, a_v, b_v, y_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // positive normal operands only, truncating
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [7:0]  ea, d;
        logic [24:0] ma, mb, s;
        if (x[30:0] < y[30:0]) begin a = y; b = x; end
        else begin a = x; b = y; end
        ea = a[30:23];
        d  = a[30:23] - b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        mb = (d > 8'd24) ? 25'd0 : (mb >> d);
        s  = ma + mb;
        if (s[24]) begin s = s >> 1; ea = ea + 8'd1; end
        return {1'b0, ea, s[22:0]};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 15;
        assign valid_v[g] = valid && (sel == g);
        assign y_v[g] = fp_mode ? fp_add(a_v[g], b_v[g]) : (a_v[g] + b_v[g]);
        fadds_pcpi_ctrl #(.ADD_LATENCY(L), .OPCODE(7'b0001011)) dut (
            .clk(clk), .resetn(resetn), .pcpi_valid(valid_v[g]), .pcpi_insn(insn),
            .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_v[g]), .pcpi_rd(rd_v[g]),
            .pcpi_wait(wait_v[g]), .pcpi_ready(rdy_v[g]), .add_a(a_v[g]), .add_b(b_v[g]),
            .add_y(y_v[g])
        );
    end

    localparam logic [6:0] OPC = 7'b0001011;

    // issue one instruction and record what the selected instance does
    task automatic run_op(input int idx, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input int lat, input bit hold,
                          output int wcnt, output int rcnt, output int wrcnt, output int rk,
                          output logic [31:0] rdv, output logic [31:0] a0,
                          output logic [31:0] b0, output bit stable);
        wcnt = 0; rcnt = 0; wrcnt = 0; rk = -1; rdv = '0; a0 = '0; b0 = '0; stable = 1'b1;
        @(negedge clk);
        sel = idx; insn = ins; rs1 = r1; rs2 = r2; valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lat + 3; k++) begin
            #1;
            if (k == 1) begin a0 = a_v[idx]; b0 = b_v[idx]; end
            if (wait_v[idx]) begin
                wcnt++;
                if (a_v[idx] !== a0 || b_v[idx] !== b0) stable = 1'b0;
            end
            if (rdy_v[idx]) begin
                rcnt++; rk = k; rdv = rd_v[idx];
                if (!hold) valid = 1'b0;
            end
            if (wr_v[idx]) wrcnt++;
            if (k < lat + 3) @(posedge clk);
        end
        if (!hold) valid = 1'b0;
    endtask

    int wc, rc, wrc, rk;
    logic [31:0] rdv, a0, b0;
    bit stb;

    task automatic test_reset();
        int cnt;
        n_cmp++; if (wait_v[1] !== 1'b0 || rdy_v[1] !== 1'b0 || wr_v[1] !== 1'b0 || rd_v[1] !== 32'h0)
            begin n_bad++; $display("FAIL reset_init: wait=%b ready=%b wr=%b rd=%h want 0", wait_v[1], rdy_v[1], wr_v[1], rd_v[1]); end
        @(negedge clk);
        sel = 1; insn = mk(7'h01, 3'b000, OPC); rs1 = 32'h5; valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (wait_v[1] !== 1'b1 || b_v[1] !== 32'h5)
            begin n_bad++; $display("FAIL reset_capture: wait=%b add_b=%h want 1/00000005", wait_v[1], b_v[1]); end
        @(posedge clk); #3;
        resetn = 1'b0; valid = 1'b0;
        #1;
        n_cmp++; if ({wait_v[1], rdy_v[1], wr_v[1]} !== 3'b000 || rd_v[1] !== 32'h0 || a_v[1] !== 32'h0 || b_v[1] !== 32'h0)
            begin n_bad++; $display("FAIL reset_async: wait=%b ready=%b wr=%b rd=%h a=%h b=%h want all 0",
                wait_v[1], rdy_v[1], wr_v[1], rd_v[1], a_v[1], b_v[1]); end
        cnt = 0;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (rdy_v[1] || wr_v[1]) cnt++; end
        n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL reset_noready: strobes=%0d want 0", cnt); end
        @(negedge clk); resetn = 1'b1;
        run_op(1, mk(7'h00, 3'b000, OPC), 32'h7, 32'h9, 3, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
        n_cmp++; if (rk != 4 || rdv !== 32'h10)
            begin n_bad++; $display("FAIL reset_after: ready_at=%0d rd=%h want 4/00000010", rk, rdv); end
    endtask

    task automatic test_fadds();
        fp_mode = 1'b1;
        run_op(0, mk(7'h00, 3'b000, OPC), 32'h3F800000, 32'h3F800000, 1, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
        fp_mode = 1'b0;
        n_cmp++; if (a0 !== 32'h3F800000 || b0 !== 32'h3F800000)
            begin n_bad++; $display("FAIL fadds_operands: a=%h b=%h want 3f800000/3f800000", a0, b0); end
        n_cmp++; if (rk != 2 || rc != 1 || wrc != 1)
            begin n_bad++; $display("FAIL fadds_handshake: ready_at=%0d ready=%0d wr=%0d want 2/1/1", rk, rc, wrc); end
        n_cmp++; if (rdv !== 32'h40000000)
            begin n_bad++; $display("FAIL fadds_result: rd=%h want 40000000", rdv); end
    endtask

    task automatic test_facc();
        logic [31:0] ins [5];
        logic [31:0] opnd [5];
        logic [31:0] exp_rd [5];
        ins  = '{mk(7'h01,3'b000,OPC), mk(7'h01,3'b000,OPC), mk(7'h02,3'b000,OPC), mk(7'h01,3'b000,OPC), mk(7'h01,3'b000,OPC)};
        opnd = '{32'h5, 32'h3, 32'h0, 32'h1, 32'h10};
        exp_rd = '{32'h5, 32'h8, 32'h8, 32'h1, 32'h11};
        for (int i = 0; i < 5; i++) begin
            run_op(0, ins[i], opnd[i], 32'hDEAD0000, 1, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
            n_cmp++; if (rc != 1 || rdv !== exp_rd[i])
                begin n_bad++; $display("FAIL facc_step%0d: ready=%0d rd=%h want 1/%h", i, rc, rdv, exp_rd[i]); end
        end
    endtask

    task automatic test_timing();
        int idxs [3];
        int lats [3];
        idxs = '{0, 2, 3};
        lats = '{1, 4, 15};
        for (int i = 0; i < 3; i++) begin
            run_op(idxs[i], mk(7'h00, 3'b000, OPC), 32'h100 * lats[i], lats[i], lats[i], 1'b0,
                   wc, rc, wrc, rk, rdv, a0, b0, stb);
            n_cmp++; if (wc != lats[i] || rk != lats[i] + 1)
                begin n_bad++; $display("FAIL timing_L%0d: wait_cycles=%0d ready_at=%0d want %0d/%0d", lats[i], wc, rk, lats[i], lats[i] + 1); end
            n_cmp++; if (rc != 1 || wrc != 1 || !stb)
                begin n_bad++; $display("FAIL pulse_L%0d: ready=%0d wr=%0d stable=%0d want 1/1/1", lats[i], rc, wrc, stb); end
            n_cmp++; if (rdv !== 32'h101 * lats[i])
                begin n_bad++; $display("FAIL sum_L%0d: rd=%h want %h", lats[i], rdv, 32'h101 * lats[i]); end
        end
    endtask

    task automatic test_unclaimed();
        logic [31:0] ins [3];
        int cnt;
        ins = '{mk(7'h05, 3'b000, OPC), mk(7'h01, 3'b001, OPC), mk(7'h01, 3'b000, 7'b0110011)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); sel = 0; insn = ins[i]; rs1 = 32'h77; rs2 = 32'h1; valid = 1'b1;
            cnt = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (wait_v[0] || rdy_v[0] || wr_v[0]) cnt++;
            end
            valid = 1'b0;
            n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL unclaimed%0d: active_cycles=%0d want 0", i, cnt); end
        end
        run_op(0, mk(7'h02, 3'b000, OPC), 32'h0, 32'h0, 1, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
        n_cmp++; if (rdv !== 32'h11) begin n_bad++; $display("FAIL unclaimed_acc: rd=%h want 00000011", rdv); end
    endtask

    task automatic test_abort();
        int cnt;
        run_op(2, mk(7'h01, 3'b000, OPC), 32'hA, 32'h0, 4, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
        n_cmp++; if (rdv !== 32'hA) begin n_bad++; $display("FAIL abort_pre: rd=%h want 0000000a", rdv); end
        @(negedge clk); sel = 2; insn = mk(7'h01, 3'b000, OPC); rs1 = 32'h14; valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                n_cmp++; if (wait_v[2] !== 1'b0) begin n_bad++; $display("FAIL abort_wait: wait=%b want 0", wait_v[2]); end
            end
            if (rdy_v[2] || wr_v[2]) cnt++;
        end
        n_cmp++; if (cnt != 0 || rd_v[2] !== 32'hA)
            begin n_bad++; $display("FAIL abort_noready: strobes=%0d rd=%h want 0/0000000a", cnt, rd_v[2]); end
        run_op(2, mk(7'h02, 3'b000, OPC), 32'h0, 32'h0, 4, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
        n_cmp++; if (rdv !== 32'hA) begin n_bad++; $display("FAIL abort_acc: rd=%h want 0000000a", rdv); end
    endtask

    task automatic test_back_to_back();
        run_op(1, mk(7'h00, 3'b000, OPC), 32'h11, 32'h22, 3, 1'b1, wc, rc, wrc, rk, rdv, a0, b0, stb);
        n_cmp++; if (wc != 3 || rc != 1 || rdv !== 32'h33 || wait_v[1] !== 1'b0)
            begin n_bad++; $display("FAIL b2b_first: wait_cycles=%0d ready=%0d rd=%h wait_now=%b want 3/1/00000033/0", wc, rc, rdv, wait_v[1]); end
        run_op(1, mk(7'h00, 3'b000, OPC), 32'h40, 32'h2, 3, 1'b0, wc, rc, wrc, rk, rdv, a0, b0, stb);
        n_cmp++; if (rk != 4 || rc != 1 || rdv !== 32'h42)
            begin n_bad++; $display("FAIL b2b_second: ready_at=%0d ready=%0d rd=%h want 4/1/00000042", rk, rc, rdv); end
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_fadds();
        test_facc();
        test_timing();
        test_unclaimed();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
